input_conditioner: RTL

//  Front-end stage between the board pins and the irrigation top level.

---
 rtl/input_conditioner_pkg.sv | 19 +
 rtl/input_conditioner_debounce_channel.sv | 63 ++++++
 rtl/input_conditioner.sv | 65 ++++++
 3 files changed

// File: rtl/input_conditioner_pkg.sv
// Shared constants and types for the irrigation input front end:
// default debounce depth, pin idle levels and the per-channel level state.
package input_conditioner_pkg;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 16;

    localparam logic SWITCH_IDLE = 1'b0;
    localparam logic BUTTON_IDLE = 1'b1;

    typedef enum logic {
        LEVEL_LOW  = 1'b0,
        LEVEL_HIGH = 1'b1
    } level_e;

    function automatic level_e to_level(input logic bit_in);
        return bit_in ? LEVEL_HIGH : LEVEL_LOW;
    endfunction

endpackage

// File: rtl/input_conditioner_debounce_channel.sv
// One debounced input: 2-FF synchroniser, run-length counter and the accepted
// level, which is a two-state machine that only moves when the counter expires.
module debounce_channel
    import input_conditioner_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter logic IDLE_LEVEL      = SWITCH_IDLE
) (
    input  logic clock,
    input  logic reset_button,
    input  logic raw,
    output logic level
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam level_e IDLE_STATE = IDLE_LEVEL ? LEVEL_HIGH : LEVEL_LOW;

    logic             sync_meta;
    logic             sync_s;
    level_e           state_q;
    level_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Synchroniser resets to the idle level so a released reset never looks like an edge.
    always_ff @(posedge clock or negedge reset_button) begin
        if (!reset_button) begin
            sync_meta <= IDLE_LEVEL;
            sync_s    <= IDLE_LEVEL;
        end else begin
            sync_meta <= raw;
            sync_s    <= sync_meta;
        end
    end

    always_ff @(posedge clock or negedge reset_button) begin
        if (!reset_button) begin
            state_q <= IDLE_STATE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Any sample that agrees with the accepted level restarts the run, so the
    // counter never climbs past CNT_LAST.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        if (sync_s != logic'(state_q)) begin
            if (cnt_q == CNT_LAST) begin
                state_d = to_level(sync_s);
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign level = (state_q == LEVEL_HIGH);

endmodule

// File: rtl/input_conditioner.sv
// Board-pin front end: debounces both switches and the active-low fertilise
// button, and turns each accepted button press into a one-cycle pulse.
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clock,
    input  logic reset_button,
    input  logic splinker_switch_raw,
    input  logic dripper_switch_raw,
    input  logic fertilise_btn_raw,
    output logic splinker_switch,
    output logic dripper_switch,
    output logic fertilise_push,
    output logic fertilise_pulse
);

    logic btn_level;
    logic btn_level_prev;

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .IDLE_LEVEL      (SWITCH_IDLE)
    ) u_splinker (
        .clock        (clock),
        .reset_button (reset_button),
        .raw          (splinker_switch_raw),
        .level        (splinker_switch)
    );

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .IDLE_LEVEL      (SWITCH_IDLE)
    ) u_dripper (
        .clock        (clock),
        .reset_button (reset_button),
        .raw          (dripper_switch_raw),
        .level        (dripper_switch)
    );

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .IDLE_LEVEL      (BUTTON_IDLE)
    ) u_fertilise (
        .clock        (clock),
        .reset_button (reset_button),
        .raw          (fertilise_btn_raw),
        .level        (btn_level)
    );

    // Previous accepted button level resets to released, so a button held through
    // reset still yields exactly one pulse once it is accepted.
    always_ff @(posedge clock or negedge reset_button) begin
        if (!reset_button) begin
            btn_level_prev <= BUTTON_IDLE;
        end else begin
            btn_level_prev <= btn_level;
        end
    end

    assign fertilise_push  = ~btn_level;
    assign fertilise_pulse = btn_level_prev & ~btn_level;

endmodule
